// File: rtl/cpu_run_controller.sv
// Run sequencer for cpu_design: loads code memory, holds/releases CPU reset,
// watches halted under a watchdog, then captures the result register.
module cpu_run_controller #(
  parameter int          ADDR_W     = 10,
  parameter int          TIMEOUT_W  = 24,
  parameter int          RST_CYCLES = 10,
  parameter int          RESULT_REG = 10,
  parameter logic [15:0] PASS_CODE  = 16'h600D
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [ADDR_W-1:0]    ld_addr,
  input  logic [31:0]          ld_data,
  input  logic                 start,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  output logic                 cm_we,
  output logic [ADDR_W-1:0]    cm_addr,
  output logic [31:0]          cm_wdata,
  output logic                 cpu_rst,
  input  logic                 halted,
  output logic [4:0]           rf_raddr,
  input  logic [31:0]          rf_rdata,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [31:0]          result,
  output logic [TIMEOUT_W-1:0] cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET_HOLD,
    S_RUN,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_t                state, state_nxt;
  logic [HOLD_W-1:0]     hold_cnt;
  logic                  accept;
  logic                  launch;
  logic                  hold_last;
  logic                  limit_hit;
  logic [TIMEOUT_W-1:0]  cycles_inc;

  // ld_ready is only high in IDLE/DONE, so a load word always wins over start.
  assign accept     = ld_valid & ld_ready;
  assign launch     = start & ~accept & ((state == S_IDLE) || (state == S_DONE));
  assign hold_last  = (hold_cnt == HOLD_W'(RST_CYCLES - 1));
  assign cycles_inc = (&cycles) ? cycles : cycles + 1'b1;
  assign limit_hit  = (timeout_limit != '0) && (cycles_inc == timeout_limit);

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (launch) state_nxt = S_RESET_HOLD;
      end
      S_RESET_HOLD: begin
        if (hold_last) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (halted)         state_nxt = S_CAPTURE;
        else if (limit_hit) state_nxt = S_DONE;
      end
      S_CAPTURE: state_nxt = S_DONE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      hold_cnt <= '0;
      cpu_rst  <= 1'b1;
      ld_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      cm_we    <= 1'b0;
      cm_addr  <= '0;
      cm_wdata <= '0;
      pass     <= 1'b0;
      timeout  <= 1'b0;
      result   <= '0;
      cycles   <= '0;
      rf_raddr <= 5'(RESULT_REG);
    end else begin
      state    <= state_nxt;
      // Status flags follow the next state so every output is a flop.
      cpu_rst  <= state_nxt inside {S_IDLE, S_RESET_HOLD, S_DONE};
      ld_ready <= state_nxt inside {S_IDLE, S_DONE};
      busy     <= state_nxt inside {S_RESET_HOLD, S_RUN, S_CAPTURE};
      done     <= (state_nxt == S_DONE);
      rf_raddr <= 5'(RESULT_REG);

      cm_we <= accept;
      if (accept) begin
        cm_addr  <= ld_addr;
        cm_wdata <= ld_data;
      end

      hold_cnt <= (state == S_RESET_HOLD && !hold_last) ? hold_cnt + 1'b1 : '0;

      if (launch) begin
        pass    <= 1'b0;
        timeout <= 1'b0;
        result  <= '0;
        cycles  <= '0;
      end

      if (state == S_RUN) begin
        cycles <= cycles_inc;
        if (!halted && limit_hit) begin
          timeout <= 1'b1;
          pass    <= 1'b0;
          result  <= '0;
        end
      end

      if (state == S_CAPTURE) begin
        result <= rf_rdata;
        pass   <= (rf_rdata[15:0] == PASS_CODE);
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: mocks the CPU (halted, register read port)
// and checks every cycle against a run-timeline model plus literal pins.
module tb_cpu_run_controller;

  localparam int AW = 10;
  localparam int TW = 12;
  localparam int R  = 10;
  localparam int SAT = (1 << TW) - 1;

  logic          clk = 0;
  logic          rst = 0;
  logic          ld_valid = 0;
  logic          ld_ready;
  logic [AW-1:0] ld_addr = '0;
  logic [31:0]   ld_data = '0;
  logic          start = 0;
  logic [TW-1:0] timeout_limit = '0;
  logic          cm_we;
  logic [AW-1:0] cm_addr;
  logic [31:0]   cm_wdata;
  logic          cpu_rst;
  logic          halted;
  logic [4:0]    rf_raddr;
  logic [31:0]   rf_rdata;
  logic          busy, done, pass, timeout;
  logic [31:0]   result;
  logic [TW-1:0] cycles;

  cpu_run_controller #(.ADDR_W(AW), .TIMEOUT_W(TW), .RST_CYCLES(R),
                       .RESULT_REG(10), .PASS_CODE(16'h600D)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_addr(ld_addr), .ld_data(ld_data), .start(start),
    .timeout_limit(timeout_limit), .cm_we(cm_we), .cm_addr(cm_addr),
    .cm_wdata(cm_wdata), .cpu_rst(cpu_rst), .halted(halted),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .result(result), .cycles(cycles)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad < 40) $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int satc(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  // Plan for the next run: RUN cycle in which the mock CPU halts (0 = never),
  // value it leaves in x10, and whether it glitches halted during reset hold.
  int          p_halt_k = 0;
  logic [31:0] p_res    = '0;
  bit          p_noise  = 0;

  // Run-timeline model: m_t = cycles since the start edge (1 = first hold cycle).
  bit          m_active = 0;
  bit          m_done   = 0;
  int          m_t      = 0;
  int          m_end    = 0;
  int          o_cycles = 0;
  logic [31:0] o_result = '0;
  bit          o_pass   = 0;
  bit          o_to     = 0;
  bit          e_we     = 0;
  logic [AW-1:0] e_addr = '0;
  logic [31:0]   e_data = '0;
  logic        m_acc;

  assign m_acc    = ld_valid && !m_active;
  assign halted   = m_active && ((p_halt_k != 0 && m_t >= R + p_halt_k) || (p_noise && m_t <= R));
  assign rf_rdata = (rf_raddr == 5'd10) ? p_res : 32'h0;

  always @(posedge clk) begin
    if (!rst) begin
      m_active <= 0; m_done <= 0; m_t <= 0;
      e_we <= 0; e_addr <= '0; e_data <= '0;
    end else begin
      e_we <= m_acc;
      if (m_acc) begin
        e_addr <= ld_addr;
        e_data <= ld_data;
      end
      if (m_active) begin
        m_t <= m_t + 1;
        if (m_t + 1 == m_end) begin
          m_active <= 0;
          m_done   <= 1;
        end
      end else if (start && !m_acc) begin
        m_active <= 1; m_done <= 0; m_t <= 1;
        if (p_halt_k != 0 && (timeout_limit == 0 || p_halt_k <= int'(timeout_limit))) begin
          m_end    <= R + p_halt_k + 2;
          o_cycles <= satc(p_halt_k);
          o_result <= p_res;
          o_pass   <= (p_res[15:0] == 16'h600D);
          o_to     <= 0;
        end else begin
          m_end    <= R + int'(timeout_limit) + 1;
          o_cycles <= int'(timeout_limit);
          o_result <= '0;
          o_pass   <= 0;
          o_to     <= 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",     busy,     m_active);
      chk("ld_ready", ld_ready, !m_active);
      chk("done",     done,     !m_active && m_done);
      chk("cpu_rst",  cpu_rst,  !m_active || m_t <= R);
      chk("cm_we",    cm_we,    e_we);
      chk("cm_addr",  cm_addr,  e_addr);
      chk("cm_wdata", cm_wdata, e_data);
      chk("rf_raddr", rf_raddr, 5'd10);
      if (m_active) begin
        chk("cycles_run", cycles, (m_t <= R) ? 0 : satc(m_t - R - 1));
        chk("status_clr", {pass, timeout, result}, '0);
      end else if (m_done) begin
        chk("cycles_done", cycles, o_cycles);
        chk("result",      result, o_result);
        chk("pass",        pass,   o_pass);
        chk("timeout",     timeout, o_to);
      end else begin
        chk("idle_status", {pass, timeout, result, cycles}, '0);
      end
    end
  end

  int wcnt  = 0;
  int rhcnt = 0;
  always @(negedge clk) begin
    if (cm_we === 1'b1) wcnt++;
    if (busy === 1'b1 && cpu_rst === 1'b1) rhcnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    tick(1);
    start = 1;
    tick(1);
    start = 0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) chk("done_wait", 0, 1);
  endtask

  logic [31:0] words [21];

  initial begin
    int w0;
    for (int i = 0; i < 21; i++) words[i] = 32'h0010_0093 ^ (i * 32'h0101_0007);

    // Reset values
    rst = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_rst",  cpu_rst,  1'b1);
    chk("rst_ld_ready", ld_ready, 1'b1);
    chk("rst_cm_we",    cm_we,    1'b0);
    chk("rst_done",     done,     1'b0);
    chk("rst_cycles",   cycles,   0);
    chk("rst_rf_raddr", rf_raddr, 5'd10);
    tick(1);
    rst = 1;
    chk_en = 1;

    // Full-rate load of 21 words
    tick(1);
    wcnt = 0;
    for (int i = 0; i < 21; i++) begin
      ld_valid = 1;
      ld_addr  = AW'(i);
      ld_data  = words[i];
      tick(1);
    end
    ld_valid = 0;
    tick(2);
    chk("load_pulses", wcnt, 21);

    // Passing run
    p_halt_k = 57; p_res = 32'h600D600D; timeout_limit = 12'd4000;
    rhcnt = 0;
    pulse_start();
    wait_done(200);
    chk("fib_pass",   pass,    1'b1);
    chk("fib_result", result,  32'h600D600D);
    chk("fib_to",     timeout, 1'b0);
    chk("fib_cycles", cycles,  57);
    chk("fib_hold",   rhcnt,   10);

    // Failing result, started from DONE
    p_halt_k = 30; p_res = 32'hDEADDEAD;
    pulse_start();
    wait_done(200);
    chk("dead_pass",   pass,   1'b0);
    chk("dead_result", result, 32'hDEADDEAD);

    // Watchdog timeout
    p_halt_k = 0; timeout_limit = 12'd100;
    pulse_start();
    wait_done(300);
    chk("to_flag",    timeout, 1'b1);
    chk("to_cycles",  cycles,  100);
    chk("to_cpu_rst", cpu_rst, 1'b1);
    chk("to_result",  result,  0);

    // Halt in the same cycle the limit hits; halted glitch during reset hold
    p_halt_k = 50; timeout_limit = 12'd50; p_res = 32'h0000600D; p_noise = 1;
    pulse_start();
    wait_done(300);
    p_noise = 0;
    chk("tie_to",     timeout, 1'b0);
    chk("tie_pass",   pass,    1'b1);
    chk("tie_cycles", cycles,  50);

    // Load and start poked during RUN
    p_halt_k = 40; p_res = 32'h600D600D; timeout_limit = 0;
    pulse_start();
    tick(R + 5);
    w0 = wcnt;
    ld_valid = 1; ld_addr = 10'd5; ld_data = 32'hBAD0BAD0; start = 1;
    tick(3);
    ld_valid = 0; start = 0;
    wait_done(300);
    chk("run_nowrite", wcnt - w0, 0);
    chk("run_cycles",  cycles,    40);

    // Reset mid-run, then a clean rerun
    p_halt_k = 60;
    pulse_start();
    tick(R + 20);
    rst = 0;
    tick(1);
    rst = 1;
    @(negedge clk);
    chk("mid_cpu_rst", cpu_rst, 1'b1);
    chk("mid_done",    done,    1'b0);
    chk("mid_cycles",  cycles,  0);
    chk("mid_busy",    busy,    1'b0);
    p_halt_k = 25;
    pulse_start();
    wait_done(300);
    chk("rerun_pass",   pass,   1'b1);
    chk("rerun_cycles", cycles, 25);

    // Load accept beats a simultaneous start
    p_halt_k = 5; p_res = 32'h1;
    tick(1);
    w0 = wcnt;
    ld_valid = 1; ld_addr = 10'h3FF; ld_data = 32'hCAFEF00D; start = 1;
    tick(1);
    ld_valid = 0;
    tick(1);
    start = 0;
    wait_done(100);
    chk("prio_write",  wcnt - w0, 1);
    chk("prio_cycles", cycles,    5);
    chk("prio_pass",   pass,      1'b0);

    // Cycle counter saturation with no watchdog
    p_halt_k = 4100; p_res = 32'h600D600D; timeout_limit = 0;
    pulse_start();
    wait_done(4300);
    chk("sat_cycles", cycles, 12'hFFF);
    chk("sat_pass",   pass,   1'b1);

    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_run_controller.md
# cpu_run_controller

Hardware run sequencer for `cpu_design`. It accepts program words from a host load port and writes them into code memory. On command it holds the CPU in reset, releases it, and watches `halted` under a watchdog cycle limit. It then reads the result register and reports a pass/fail/timeout status together with the cycle count. It replaces the behavioural load/run/check flow so the same programs can run on silicon/FPGA and in regression.

## Interface
Parameters:
- `ADDR_W`, 10: code memory word address width.
- `TIMEOUT_W`, 24: width of cycle counter and timeout limit.
- `RST_CYCLES`, 10: number of cycles the CPU reset is held before a run.
- `RESULT_REG`, 10: register index read as the test result.
- `PASS_CODE`, 16'h600D: value of result[15:0] that means pass.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `ld_valid`  in  1  host load word valid.
- `ld_ready`  out  1  controller can accept a load word.
- `ld_addr`  in  ADDR_W  code memory word address.
- `ld_data`  in  32  instruction word.
- `start`  in  1  run request (level sampled, acts on one cycle).
- `timeout_limit`  in  TIMEOUT_W  max RUN cycles; 0 = no timeout.
- `cm_we`  out  1  code memory write enable.
- `cm_addr`  out  ADDR_W  code memory write address.
- `cm_wdata`  out  32  code memory write data.
- `cpu_rst`  out  1  CPU reset, active-high, drives `cpu_design.rst`.
- `halted`  in  1  CPU halted (EBREAK retired).
- `rf_raddr`  out  5  register bank debug read address.
- `rf_rdata`  in  32  register bank read data, combinational from `rf_raddr`.
- `busy`  out  1  in RESET_HOLD, RUN or CAPTURE.
- `done`  out  1  a run has completed; status valid.
- `pass`  out  1  result[15:0] == PASS_CODE.
- `timeout`  out  1  run ended by watchdog.
- `result`  out  32  captured result register.
- `cycles`  out  TIMEOUT_W  RUN cycles consumed.

## Operation
- States: IDLE, RESET_HOLD, RUN, CAPTURE, DONE.
- Reset (`rst`=0 at an edge) puts the block in IDLE with `cpu_rst`=1, `ld_ready`=1, `cm_we`=0, `cm_addr`=0, `cm_wdata`=0, `busy`=0, `done`=0, `pass`=0, `timeout`=0, `result`=0, `cycles`=0, `rf_raddr`=RESULT_REG. This holds mid-run too: the CPU is re-held in reset and status is cleared.
- IDLE/DONE: `ld_ready`=1. A word is accepted when `ld_valid`&`ld_ready`. `cm_*` is registered from the accepted word on the next cycle, with `cm_we` high for exactly one cycle per accepted word. Back-to-back words at full rate.
- In any other state `ld_ready`=0, and `ld_valid` is ignored with no write.
- `start` in IDLE/DONE, with no accept that cycle (a load accept has priority, and start is sampled again next cycle), goes to RESET_HOLD. It clears `done`, `pass`, `timeout`, `result`, `cycles`.
- `start` in other states is ignored.
- RESET_HOLD: `cpu_rst`=1 for exactly RST_CYCLES cycles, then RUN. `halted` is ignored.
- RUN: `cpu_rst`=0. Each RUN cycle, `cycles` increments (saturating at all-ones).
    - If `halted`=1, go to CAPTURE. Halted takes priority over timeout.
    - Otherwise, if `timeout_limit`≠0 and the incremented `cycles` equals `timeout_limit`, go to DONE with `timeout`=1, `pass`=0, `result`=0.
- CAPTURE: one cycle with `rf_raddr`=RESULT_REG. `result`<=`rf_rdata` and `pass`<=(`rf_rdata[15:0]`==PASS_CODE). Then DONE. `cpu_rst` stays 0 in CAPTURE so register contents are preserved.
- DONE: `done`=1, `cpu_rst`=1 (CPU frozen). Status holds until `start` or reset.
- `busy` = state ∈ {RESET_HOLD, RUN, CAPTURE}. All outputs are registered.

## Timing
- Load: `ld_valid`&`ld_ready` at edge N gives `cm_we`=1 with that addr/data during cycle N+1.
- Start at edge S:
    - RESET_HOLD occupies cycles S+1..S+RST_CYCLES.
    - First RUN cycle (`cpu_rst`=0) is S+RST_CYCLES+1.
- `halted` seen high in the k-th RUN cycle gives `cycles`=k, CAPTURE next cycle, and `done`=1 the cycle after.
- Timeout: `done`/`timeout` rise on the cycle after the `timeout_limit`-th RUN cycle.
- `timeout_limit` is sampled every RUN cycle. The host keeps it stable while `busy`.

## Test plan
- Load fibonacci program (words 0–20) at full rate, `timeout_limit`=4000, start. Expect 21 single-cycle `cm_we` pulses with matching addr/data, `cpu_rst` high exactly 10 cycles, then `done`=1, `pass`=1, `result`=0x600D600D, `timeout`=0, `cycles` = halt cycle index.
- Program whose x10 ends as 0xDEADDEAD. Expect `done`=1, `pass`=0, `result`=0xDEADDEAD.
- Program looping forever (`jal x0,0`), `timeout_limit`=100. Expect `done`=1 exactly after 100 RUN cycles, `timeout`=1, `cycles`=100, `cpu_rst`=1.
- Halted asserted in the same RUN cycle the limit is hit. Expect CAPTURE path: `timeout`=0, result captured.
- `ld_valid` and `start` pulsed during RUN. Expect `ld_ready`=0, no `cm_we`, run unaffected. Start from DONE reruns the program with status cleared.
- Drive `rst`=0 mid-RUN. Expect IDLE next cycle with `cpu_rst`=1, `done`=0, `cycles`=0. A subsequent start completes normally.
